amiga_clk_pll: RTL and testbench

- Synthesizable model of the Amiga clock PLL that feeds the Minimig clock/enable generator.
- Derives three clock outputs from one reference clock using numerically-controlled-oscillator (NCO) phase accumulators:
  - c0: SDRAM pin clock, same frequency as c1, phase-shifted −146.25°.
  - c1: SDRAM controller clock.
  - c2: 28 MHz-class chipset clock.
- Asserts locked after a fixed settle time. The downstream 7 MHz / CCK / E-clock logic is held in reset by !locked.

---
 rtl/amiga_clk_pkg.sv | 24 ++
 rtl/amiga_clk_nco.sv | 32 +++
 rtl/amiga_clk_pll.sv | 63 ++++++
 tb/tb_amiga_clk_pll.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/amiga_clk_pkg.sv
// Shared constants for the Amiga clock PLL: accumulator width, default increments
// and helpers for deriving production increments from target frequencies.
`default_nettype none
package amiga_clk_pkg;

  localparam int PLL_ACC_W = 32;

  localparam logic [PLL_ACC_W-1:0] PLL_INC1   = 32'h8000_0000;
  localparam logic [PLL_ACC_W-1:0] PLL_INC2   = 32'h2000_0000;
  localparam logic [PLL_ACC_W-1:0] PLL_PHASE0 = 32'h9800_0000;

  // Production frequencies: 28.375160 MHz chipset clock, 114.75 MHz SDRAM clock.
  localparam longint unsigned F_CHIP_HZ  = 64'd28_375_160;
  localparam longint unsigned F_SDRAM_HZ = 64'd114_750_000;

  function automatic logic [PLL_ACC_W-1:0] nco_inc(input longint unsigned f_out,
                                                   input longint unsigned f_ref);
    return PLL_ACC_W'((f_out << PLL_ACC_W) / f_ref);
  endfunction

  localparam logic [PLL_ACC_W-1:0] INC_CHIP_OF_SDRAM = nco_inc(F_CHIP_HZ, F_SDRAM_HZ);

endpackage
`default_nettype wire

// File: rtl/amiga_clk_nco.sv
// Phase-accumulator NCO: resets to INIT, advances by INC while enabled,
// and exposes the accumulator MSB as the synthesized clock.
`default_nettype none
module amiga_clk_nco #(
  parameter int           W    = 32,
  parameter logic [W-1:0] INIT = '0,
  parameter logic [W-1:0] INC  = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic msb_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Natural modulo-2^W wrap gives the dithered average for non-dividing increments.
  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = acc_q + INC;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= INIT;
    else         acc_q <= acc_d;
  end

  assign msb_o = acc_q[W-1];

endmodule
`default_nettype wire

// File: rtl/amiga_clk_pll.sv
// Amiga clock PLL model: three NCO-derived clocks gated by a registered lock
// indicator that asserts a fixed number of reference edges after reset release.
`default_nettype none
module amiga_clk_pll
  import amiga_clk_pkg::*;
#(
  parameter int                 ACC_W       = PLL_ACC_W,
  parameter logic [ACC_W-1:0]   INC1        = ACC_W'(PLL_INC1),
  parameter logic [ACC_W-1:0]   INC2        = ACC_W'(PLL_INC2),
  parameter logic [ACC_W-1:0]   PHASE0      = ACC_W'(PLL_PHASE0),
  parameter int                 LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic areset_n,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           msb0, msb1, msb2;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) locked_d   = 1'b1;
      else                                     lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // c0 shares INC1 with c1, so their phase offset stays fixed at PHASE0.
  amiga_clk_nco #(.W(ACC_W), .INIT(PHASE0), .INC(INC1)) u_nco0 (
    .clk_i(inclk0), .rst_ni(areset_n), .en_i(locked_q), .msb_o(msb0)
  );
  amiga_clk_nco #(.W(ACC_W), .INIT('0), .INC(INC1)) u_nco1 (
    .clk_i(inclk0), .rst_ni(areset_n), .en_i(locked_q), .msb_o(msb1)
  );
  amiga_clk_nco #(.W(ACC_W), .INIT('0), .INC(INC2)) u_nco2 (
    .clk_i(inclk0), .rst_ni(areset_n), .en_i(locked_q), .msb_o(msb2)
  );

  assign c0     = msb0 & locked_q;
  assign c1     = msb1 & locked_q;
  assign c2     = msb2 & locked_q;
  assign locked = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_amiga_clk_pll.sv
// Self-checking bench for amiga_clk_pll: closed-form model scoreboard across three
// parameterisations, a hand table for the default build, and reset/wrap sequences.
`default_nettype none
module tb_amiga_clk_pll;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: defaults. DUT 1: INC1=1000_0000, INC2=3000_0000. DUT 2: LOCK_CYCLES=1.
  logic [3:0] act [3];
  logic d0_c0, d0_c1, d0_c2, d0_l;
  logic d1_c0, d1_c1, d1_c2, d1_l;
  logic d2_c0, d2_c1, d2_c2, d2_l;

  amiga_clk_pll u_dut0 (
    .inclk0(clk), .areset_n(areset_n), .c0(d0_c0), .c1(d0_c1), .c2(d0_c2), .locked(d0_l)
  );
  amiga_clk_pll #(.INC1(32'h1000_0000), .INC2(32'h3000_0000)) u_dut1 (
    .inclk0(clk), .areset_n(areset_n), .c0(d1_c0), .c1(d1_c1), .c2(d1_c2), .locked(d1_l)
  );
  amiga_clk_pll #(.LOCK_CYCLES(1)) u_dut2 (
    .inclk0(clk), .areset_n(areset_n), .c0(d2_c0), .c1(d2_c1), .c2(d2_c2), .locked(d2_l)
  );

  assign act[0] = {d0_l, d0_c2, d0_c1, d0_c0};
  assign act[1] = {d1_l, d1_c2, d1_c1, d1_c0};
  assign act[2] = {d2_l, d2_c2, d2_c1, d2_c0};

  int nvec  = 0;
  int nfail = 0;

  // Expected {locked,c2,c1,c0} at edge k after release, from accumulator arithmetic.
  function automatic logic [3:0] model(input int d, input int k);
    int unsigned lc, inc1, inc2, ph0, a0, a1, a2, n;
    lc = 16; inc1 = 32'h8000_0000; inc2 = 32'h2000_0000; ph0 = 32'h9800_0000;
    if (d == 1) begin inc1 = 32'h1000_0000; inc2 = 32'h3000_0000; end
    if (d == 2) lc = 1;
    if (k < int'(lc)) return 4'b0000;
    n  = k - lc;
    a0 = ph0 + n * inc1;
    a1 = n * inc1;
    a2 = n * inc2;
    return {1'b1, a2[31], a1[31], a0[31]};
  endfunction

  typedef struct { int dut; int edge_no; logic [3:0] exp; } sb_t;
  sb_t sbq[$];

  typedef struct { int edge_no; logic [3:0] exp; } vec_t;
  vec_t tab[12];
  int   ti = 0;
  int   edge_k = 0;

  logic c2_hist [48];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic run_edges(input int n, input bit use_tab);
    sb_t s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_k++;
      for (int d = 0; d < 3; d++) sbq.push_back('{d, edge_k, model(d, edge_k)});
      #1;
      while (sbq.size() > 0) begin
        s = sbq.pop_front();
        check($sformatf("sb dut%0d edge%0d", s.dut, s.edge_no), act[s.dut], s.exp);
      end
      if (use_tab && ti < 12 && tab[ti].edge_no == edge_k) begin
        check($sformatf("tab edge%0d", edge_k), act[0], tab[ti].exp);
        ti++;
      end
      if (edge_k >= 16 && edge_k - 16 < 48) c2_hist[edge_k - 16] = d1_c2;
    end
  endtask

  initial begin
    int highs, rep_bad, inv_bad;
    tab[0]  = '{1,  4'b0000};
    tab[1]  = '{8,  4'b0000};
    tab[2]  = '{15, 4'b0000};
    tab[3]  = '{16, 4'b1001};
    tab[4]  = '{17, 4'b1010};
    tab[5]  = '{18, 4'b1001};
    tab[6]  = '{19, 4'b1010};
    tab[7]  = '{20, 4'b1101};
    tab[8]  = '{23, 4'b1110};
    tab[9]  = '{24, 4'b1001};
    tab[10] = '{27, 4'b1010};
    tab[11] = '{28, 4'b1101};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("reset dut%0d", d), act[d], 4'b0000);

    @(negedge clk);
    areset_n = 1'b1;
    edge_k = 0;
    run_edges(70, 1'b1);
    if (ti != 12) begin
      nvec++; nfail++;
      $display("FAIL table coverage: got %0d expected 12", ti);
    end

    // c2 with INC2=3000_0000: 8 highs per 16 edges, periodic across wrap.
    highs = 0; rep_bad = 0;
    for (int i = 0; i < 16; i++) if (c2_hist[i]) highs++;
    for (int i = 0; i < 32; i++) if (c2_hist[i] !== c2_hist[i + 16]) rep_bad++;
    check("wrap c2 highs", 4'(highs), 4'd8);
    check("wrap c2 period", 4'(rep_bad), 4'd0);

    // Asynchronous reset between edges must clear everything at once.
    @(posedge clk);
    edge_k++;
    #3 areset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("async rst dut%0d", d), act[d], 4'b0000);
    @(posedge clk);
    #1 check("rst held dut0", act[0], 4'b0000);

    @(negedge clk);
    areset_n = 1'b1;
    edge_k = 0;
    inv_bad = 0;
    for (int i = 0; i < 30; i++) begin
      run_edges(1, 1'b0);
      if (edge_k >= 16 && d0_c0 === d0_c1) inv_bad++;
    end
    check("relock c0 inverse of c1", 4'(inv_bad), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
